serial_word_tx: RTL

Parallel-to-serial bit transmitter that drives the single-bit serial line `x` consumed by the team's Moore sequence-detector state machines. A client loads a `WIDTH`-bit word with a ready/load handshake. The block then shifts it out LSB-first, one bit per clock, with an optional stall input and a guaranteed idle gap between words. It also reports the number of ones in each accepted word, so benches and upstream logic can predict the detector's `z` pulses.

---
 rtl/serial_word_tx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - parallel-to-serial LSB-first word transmitter with idle gap
//
// Purpose:
//   Accepts a WIDTH-bit word through a ready/load handshake and shifts it
//   out on the single-bit line x, LSB first, one bit per clock. Shifting can
//   be stalled with hold. After the last bit the line is forced low for
//   GAP_CYCLES cycles before the next word can be taken. The popcount of
//   every accepted word is reported on ones_count.
//
// Parameters:
//   WIDTH       bits per word (>= 2)
//   GAP_CYCLES  forced idle cycles after each word (0 allowed)
//
// Ports:
//   clock       rising-edge clock
//   n_reset     asynchronous active-low reset
//   load        request to accept data (honoured only while ready=1)
//   data        word to transmit, sampled on the accepting edge
//   hold        stall; freezes shifting while in SHIFT
//   ready       high only in IDLE (state decode)
//   x           registered serial data line
//   busy        high in SHIFT and GAP (state decode)
//   done        registered one-cycle pulse after the last bit leaves
//   ones_count  registered popcount of the last accepted word

module serial_word_tx #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                       clock,
  input  logic                       n_reset,
  input  logic                       load,
  input  logic [WIDTH-1:0]           data,
  input  logic                       hold,
  output logic                       ready,
  output logic                       x,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] ones_count
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = $clog2(WIDTH);
  // A zero or one-cycle gap still needs a 1-bit counter to keep widths legal.
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shifted;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [CW-1:0]    data_ones;

  assign ready        = (state == S_IDLE);
  assign busy         = (state == S_SHIFT) || (state == S_GAP);
  assign sreg_shifted = sreg >> 1;

  always_comb begin
    data_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      data_ones = data_ones + CW'(data[i]);
    end
  end

  // x is registered so that it always equals bit 0 of the shift register
  // while in SHIFT; it is loaded with the same value the register takes.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state      <= S_IDLE;
      sreg       <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      x          <= 1'b0;
      done       <= 1'b0;
      ones_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          x <= 1'b0;
          if (load) begin
            state      <= S_SHIFT;
            sreg       <= data;
            bit_cnt    <= '0;
            ones_count <= data_ones;
            x          <= data[0];
          end
        end

        S_SHIFT: begin
          if (!hold) begin
            sreg <= sreg_shifted;
            if (bit_cnt == BIT_LAST) begin
              // Final bit has been on the line for its cycle: drop x,
              // flag done and go idle directly when no gap is configured.
              bit_cnt <= '0;
              gap_cnt <= '0;
              x       <= 1'b0;
              done    <= 1'b1;
              state   <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              x       <= sreg_shifted[0];
            end
          end
        end

        S_GAP: begin
          x <= 1'b0;
          if (gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          x     <= 1'b0;
        end
      endcase
    end
  end

endmodule
